// File: rtl/cpu_run_pkg.sv
// Shared types for the CPU run controller: FSM states, run result codes and
// the termination-priority helper.
package cpu_run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RESET_DUT = 2'd1,
    ST_RUN       = 2'd2,
    ST_DONE      = 2'd3
  } run_state_t;

  typedef enum logic [1:0] {
    RS_NONE    = 2'd0,
    RS_HALT    = 2'd1,
    RS_STALL   = 2'd2,
    RS_TIMEOUT = 2'd3
  } run_status_t;

  // Several end conditions can land on the same cycle; the explicit halt
  // is the most informative, a stall next, a plain timeout last.
  function automatic run_status_t resolve_term(input logic halt,
                                               input logic stall,
                                               input logic timeout);
    if (halt)    return RS_HALT;
    if (stall)   return RS_STALL;
    if (timeout) return RS_TIMEOUT;
    return RS_NONE;
  endfunction

endpackage

// File: rtl/pc_stall_detector.sv
// Flags a stuck program counter: counts consecutive cycles where pc repeats
// the previous cycle's value while enabled.
module pc_stall_detector #(
  parameter int PC_W        = 64,
  parameter int STALL_LIMIT = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [PC_W-1:0] pc,
  output logic            stall
);

  localparam int SC_W = $clog2(STALL_LIMIT + 1);

  logic [PC_W-1:0] prev_pc;
  logic            have_prev;
  logic [SC_W-1:0] stall_cnt;
  logic            same;

  // No comparison on the first enabled cycle: there is no previous pc yet.
  assign same  = enable && have_prev && (pc == prev_pc);
  // Fires on the repeat that brings the count to STALL_LIMIT, so the caller
  // can terminate on that very cycle.
  assign stall = same && (stall_cnt == SC_W'(STALL_LIMIT - 1));

  // Track previous pc and the run length of repeats; disabling clears history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_pc   <= '0;
      have_prev <= 1'b0;
      stall_cnt <= '0;
    end else if (!enable) begin
      have_prev <= 1'b0;
      stall_cnt <= '0;
    end else begin
      prev_pc   <= pc;
      have_prev <= 1'b1;
      if (!same)
        stall_cnt <= '0;
      else if (stall_cnt != SC_W'(STALL_LIMIT))
        stall_cnt <= stall_cnt + SC_W'(1);
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for a CPU under test: holds it in reset, releases it for a
// bounded run, and reports why the run ended (halt, stall or timeout).
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter  int RESET_CYCLES = 2,
  parameter  int MAX_CYCLES   = 1500,
  parameter  int STALL_LIMIT  = 8,
  parameter  int PC_W         = 64,
  localparam int CNT_W        = $clog2(MAX_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  input  logic             halt_req,
  output logic             cpu_reset,
  output logic             cpu_run,
  output logic             busy,
  output logic             done,
  output run_status_t      status,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int RC_W = $clog2(RESET_CYCLES + 1);

  if (RESET_CYCLES < 1 || MAX_CYCLES < 1 || STALL_LIMIT < 2) begin : g_param_err
    $error("cpu_run_ctrl: RESET_CYCLES>=1, MAX_CYCLES>=1, STALL_LIMIT>=2 required");
  end

  run_state_t       state, state_nxt;
  logic [RC_W-1:0]  rst_cnt, rst_cnt_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  run_status_t      status_nxt;
  logic             stall;
  logic             tmo;

  pc_stall_detector #(
    .PC_W        (PC_W),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stall (
    .clk    (clk),
    .reset  (reset),
    .enable (state == ST_RUN),
    .pc     (pc),
    .stall  (stall)
  );

  // Next-state, reset-length counter, run counter and result code.
  always_comb begin
    state_nxt   = state;
    rst_cnt_nxt = rst_cnt;
    cnt_nxt     = cycle_count;
    status_nxt  = status;
    tmo         = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt   = ST_RESET_DUT;
          rst_cnt_nxt = '0;
          cnt_nxt     = '0;
          status_nxt  = RS_NONE;
        end
      end
      ST_RESET_DUT: begin
        if (rst_cnt == RC_W'(RESET_CYCLES - 1))
          state_nxt = ST_RUN;
        else
          rst_cnt_nxt = rst_cnt + RC_W'(1);
      end
      ST_RUN: begin
        // The terminating cycle is itself counted.
        if (cycle_count != CNT_W'(MAX_CYCLES))
          cnt_nxt = cycle_count + CNT_W'(1);
        tmo = (cnt_nxt == CNT_W'(MAX_CYCLES));
        if (halt_req || stall || tmo) begin
          state_nxt  = ST_DONE;
          status_nxt = resolve_term(halt_req, stall, tmo);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      rst_cnt     <= '0;
      cycle_count <= '0;
      status      <= RS_NONE;
      cpu_reset   <= 1'b1;
      cpu_run     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      rst_cnt     <= rst_cnt_nxt;
      cycle_count <= cnt_nxt;
      status      <= status_nxt;
      cpu_reset   <= (state_nxt == ST_IDLE) || (state_nxt == ST_RESET_DUT);
      cpu_run     <= (state_nxt == ST_RUN);
      busy        <= (state_nxt == ST_RESET_DUT) || (state_nxt == ST_RUN);
      done        <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed runs with hand-computed results; a
// scoreboard queue per instance is checked whenever done rises.
module tb_cpu_run_ctrl;

  typedef struct {
    int st;
    int cnt;
    int rc;
    int nc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, halt_req;
  logic [63:0] pc;
  logic        cpu_reset, cpu_run, busy, done;
  logic [1:0]  status;
  logic [10:0] cycle_count;

  logic        s_start, s_halt;
  logic [63:0] s_pc;
  logic        s_cpu_reset, s_cpu_run, s_busy, s_done;
  logic [1:0]  s_status;
  logic [1:0]  s_cycle_count;

  int checks = 0;
  int failures = 0;
  exp_t q[$];
  exp_t qs[$];

  always #5 clk = ~clk;

  cpu_run_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .halt_req(halt_req),
    .cpu_reset(cpu_reset), .cpu_run(cpu_run), .busy(busy), .done(done),
    .status(status), .cycle_count(cycle_count)
  );

  cpu_run_ctrl #(.MAX_CYCLES(3), .RESET_CYCLES(1)) u_dut_s (
    .clk(clk), .reset(reset), .start(s_start), .pc(s_pc), .halt_req(s_halt),
    .cpu_reset(s_cpu_reset), .cpu_run(s_cpu_run), .busy(s_busy), .done(s_done),
    .status(s_status), .cycle_count(s_cycle_count)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor for the default instance: tallies reset/run cycles, checks on done.
  int rc = 0, nc = 0;
  logic done_q = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      rc = 0; nc = 0; done_q = 1'b0;
    end else begin
      if (busy && cpu_reset) rc++;
      if (cpu_run) nc++;
      if (done && !done_q) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("status", longint'(status), e.st);
          chk("cycle_count", longint'(cycle_count), e.cnt);
          chk("cpu_reset_cycles", rc, e.rc);
          chk("cpu_run_cycles", nc, e.nc);
        end
        rc = 0; nc = 0;
      end
      done_q = done;
    end
  end

  // Monitor for the small instance.
  int src = 0, snc = 0;
  logic sdone_q = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      src = 0; snc = 0; sdone_q = 1'b0;
    end else begin
      if (s_busy && s_cpu_reset) src++;
      if (s_cpu_run) snc++;
      if (s_done && !sdone_q) begin
        if (qs.size() == 0) chk("s_unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = qs.pop_front();
          chk("s_status", longint'(s_status), e.st);
          chk("s_cycle_count", longint'(s_cycle_count), e.cnt);
          chk("s_cpu_reset_cycles", src, e.rc);
          chk("s_cpu_run_cycles", snc, e.nc);
        end
        src = 0; snc = 0;
      end
      sdone_q = s_done;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Drives one run, cycle k = 1.. of RUN. pc = base + 4*(k-1), held from
  // cycle 'freeze' on (0 = never). halt/start pulse at the given cycle,
  // reset is pulled low at cycle rst_at (0 = never).
  task automatic run_drive(input logic [63:0] base, input int freeze,
                           input int halt_at, input int start_at, input int rst_at);
    int k, w;
    w = 0;
    while (!cpu_run && w < 20) begin @(posedge clk); #1; w++; end
    if (!cpu_run) begin chk("run_entry_timeout", 0, 1); return; end
    k = 1;
    while (cpu_run && k <= 1600) begin
      pc       = base + 64'(4 * (((freeze > 0) && (k > freeze)) ? freeze - 1 : k - 1));
      halt_req = (k == halt_at);
      start    = (k == start_at);
      if (k == rst_at) begin
        reset = 1'b0;
        #1;
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_cpu_run", cpu_run, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_status", status, 0);
        halt_req = 1'b0; start = 1'b0;
        return;
      end
      @(posedge clk); #1;
      k++;
    end
    halt_req = 1'b0;
    start    = 1'b0;
    if (cpu_run) chk("run_exit_timeout", 0, 1);
  endtask

  // Small instance: MAX_CYCLES=3, RESET_CYCLES=1 -> 1 reset, 3 run cycles.
  initial begin
    s_start = 1'b0; s_halt = 1'b0; s_pc = '0;
    wait (reset === 1'b1);
    @(posedge clk); #1;
    qs.push_back('{3, 3, 1, 3});
    s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
  end

  initial begin
    reset = 1'b0; start = 1'b0; halt_req = 1'b0; pc = '0;
    #12;
    chk("init_cpu_reset", cpu_reset, 1);
    chk("init_cpu_run", cpu_run, 0);
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_status", status, 0);
    chk("init_cycle_count", cycle_count, 0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_cpu_reset", cpu_reset, 1);

    // Free-running pc, halt_req high outside RUN must be ignored -> timeout.
    halt_req = 1'b1;
    q.push_back('{3, 1500, 2, 1500});
    pulse_start();
    run_drive(64'h0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("done_cpu_reset", cpu_reset, 0);
    chk("done_cpu_run", cpu_run, 0);
    chk("done_flag", done, 1);

    // pc settles at 0x40 on cycle 9; repeats on 10..17 -> stall at 17.
    q.push_back('{2, 17, 2, 17});
    pulse_start();
    run_drive(64'h20, 9, 0, 0, 0);

    // Same run with halt on cycle 17: halt wins.
    q.push_back('{1, 17, 2, 17});
    pulse_start();
    run_drive(64'h20, 9, 17, 0, 0);

    // start during RUN ignored; halt at 30.
    q.push_back('{1, 30, 2, 30});
    pulse_start();
    run_drive(64'h0, 0, 30, 10, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_status", status, 1);
    chk("hold_cycle_count", cycle_count, 30);

    // start in DONE clears results and runs again.
    q.push_back('{1, 3, 2, 3});
    pulse_start();
    chk("restart_cycle_count", cycle_count, 0);
    chk("restart_status", status, 0);
    chk("restart_busy", busy, 1);
    chk("restart_done", done, 0);
    run_drive(64'h0, 0, 3, 0, 0);

    // Reset mid-run at cycle 50, then a fresh full run.
    pulse_start();
    run_drive(64'h0, 0, 0, 0, 50);
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_cpu_reset", cpu_reset, 1);
    q.push_back('{1, 5, 2, 5});
    pulse_start();
    run_drive(64'h0, 0, 5, 0, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", q.size(), 0);
    chk("s_sb_empty", qs.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
